read_data_reassembly: RTL and testbench
=======================================

// Module: read_data_reassembly
// PURPOSE
// - Parametrised read-data staging block between the PSL read-data buffer interface and the AFU read/WED consumers.
// - Stores BEATS data beats per cacheline in a tag-indexed RAM and tracks received beats per tag.
// - On each PSL response for a tag, streams that tag's line out in beat order on one valid/ready port.
// - Checks tag parity and data parity, and reports incomplete lines and response overflow.
// PARAMETERS
// - TAG_COUNT       256  outstanding tags (RAM lines); TAG_W = $clog2(TAG_COUNT)
// - BEATS           2    beats per cacheline; BEAT_W = max(1,$clog2(BEATS))
// - DATA_W          512  bits per beat; multiple of 64
// - RSP_FIFO_DEPTH  16   queued responses awaiting drain; power of 2
// PORTS
// - clock             in   1          single clock; all logic on rising edge
// - rst               in   1          asynchronous, active-high reset
// - enabled_in        in   1          block enable; registered once internally
// - wr_valid          in   1          PSL buffer write strobe
// - wr_tag            in   TAG_W      tag of the beat
// - wr_tag_parity     in   1          odd parity of wr_tag
// - wr_beat           in   BEAT_W     beat index within line (buffer write address)
// - wr_data           in   DATA_W     beat data
// - wr_parity         in   DATA_W/64  odd parity per 64-bit double word
// - wr_cmd_kind       in   2          tag-table kind for wr_tag, same cycle: 0 none, 1 READ, 2 WED
// - rsp_valid         in   1          PSL response strobe
// - rsp_tag           in   TAG_W      responding tag
// - rsp_ok            in   1          response code DONE; other codes are ignored
// - out_valid         out  1          beat available
// - out_ready         in   1          consumer accepts beat
// - out_tag           out  TAG_W      tag of the streamed line
// - out_kind          out  2          stored kind (1 READ, 2 WED)
// - out_beat          out  BEAT_W     beat index
// - out_last          out  1          final beat of line
// - out_data          out  DATA_W     beat data
// - data_read_error   out  4          {tag_par, data_par, incomplete, rsp_overflow}; 1-cycle pulses
// BEHAVIOUR
// - Reset: all outputs 0; beat bitmaps clear; FIFO empty; FSM IDLE. RAM contents are not reset.
// - enabled_in is registered to `enabled`.
// - When `enabled` = 0: inputs are ignored; FIFO is flushed; bitmaps clear; FSM forced to IDLE.
//   This also applies mid-stream: out_valid drops the next cycle with no out_last.
// - Write path: inputs are latched 1 cycle.
//   - If kind is 1 or 2: RAM[{tag,beat}] <= data, bitmap[tag][beat] <= 1, kind[tag] <= kind.
//   - Kind 0: write is dropped.
// - Parity: computed on the latched beat; mismatch pulses tag_par / data_par 2 cycles after wr_valid.
//   Errored beats are still stored.
// - Response path: rsp_valid && rsp_ok pushes rsp_tag into the FIFO.
//   - Push while full: the response is dropped and rsp_overflow pulses.
//   - Push and pop in the same cycle while full are both allowed.
// - FSM:
//   - IDLE: FIFO non-empty -> pop, snapshot bitmap[tag], clear bitmap[tag], beat=0, -> FETCH.
//   - FETCH: 1-cycle RAM read of {tag,beat} -> STREAM.
//   - STREAM: out_valid=1. On out_ready:
//     - beat==BEATS-1 -> IDLE (out_last=1 on that beat);
//     - otherwise beat+1 and -> FETCH.
//   - Outputs hold stable while out_valid && !out_ready.
// - Latency: response to first out_valid is 3 cycles (FIFO reg, FETCH, STREAM) when idle.
//   Throughput: 1 beat per 2 cycles.
// - Incomplete: if the snapshot has any 0 bit at drain start, incomplete pulses.
//   The line is still streamed; missing beats carry stale RAM data.
// - A write to the tag currently draining lands in the cleared bitmap and counts toward the tag's next use.
//   Same-cycle snapshot clear and write to the same tag: the write's bit survives.
// - Write and response for the same tag in the same cycle: the write is ordered first.
// - Beat counter wraps at BEATS-1 (no arithmetic overflow); wr_beat >= BEATS is dropped.
// STRUCTURE
// - Shared AFU package: ReadKind enum {NONE,READ,WED}, ReadBeatOut struct (tag, kind, beat, last, data),
//   ReassemblyError struct, FSM state enum.
// - Existing ram, parity, and dw_parity blocks are reused for storage and parity checks.
// - One natural sub-module: rsp_tag_fifo (sync FIFO, TAG_W x RSP_FIFO_DEPTH, full/empty flags).
// TESTING
// - BEATS=2: READ tag 0x05 beats 0,1 (data A,B), then rsp 0x05
//   -> 2 beats A then B, out_kind=1, out_last on beat 1, no errors.
// - Tag 0x07 beats stored; rsp with out_ready held low 10 cycles -> outputs stable, then beat 0 and 1 delivered in order.
// - Beat 0 only for tag 0x09, then rsp -> incomplete pulse; 2 beats streamed.
// - Flip wr_tag_parity -> tag_par pulse; corrupt one dword parity -> data_par pulse; data still stored.
// - 17 rsp with out_ready=0, DEPTH=16 -> one rsp_overflow pulse; 16 lines later drained.
// - Drop enabled_in mid-stream -> out_valid 0; FIFO empty; re-enable and fresh line streams correctly.
// - rst asserted mid-FETCH -> all outputs 0 asynchronously; FSM IDLE after release.

Source files
------------

// File: rtl/read_data_reassembly_pkg.sv
// rtl/read_data_reassembly_pkg.sv - shared types for read-data reassembly
package read_data_reassembly_pkg;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_READ = 2'd1,
    KIND_WED  = 2'd2
  } read_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM
  } fsm_state_e;

  typedef struct packed {
    logic tag_par;
    logic data_par;
    logic incomplete;
    logic rsp_overflow;
  } reassembly_error_t;

  // High when a 64-bit double word and its odd-parity bit disagree.
  function automatic logic dw_parity_err(input logic [63:0] dw, input logic par);
    return ~^{dw, par};
  endfunction

endpackage

// File: rtl/read_data_reassembly_if.sv
// rtl/read_data_reassembly_if.sv - PSL write/response and beat-out bundle
interface read_data_reassembly_if #(
  parameter int TAG_COUNT = 256,
  parameter int BEATS     = 2,
  parameter int DATA_W    = 512
);
  localparam int TAG_W  = $clog2(TAG_COUNT);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                  wr_valid;
  logic [TAG_W-1:0]      wr_tag;
  logic                  wr_tag_parity;
  logic [BEAT_W-1:0]     wr_beat;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/64-1:0]  wr_parity;
  logic [1:0]            wr_cmd_kind;
  logic                  rsp_valid;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  rsp_ok;
  logic                  out_valid;
  logic                  out_ready;
  logic [TAG_W-1:0]      out_tag;
  logic [1:0]            out_kind;
  logic [BEAT_W-1:0]     out_beat;
  logic                  out_last;
  logic [DATA_W-1:0]     out_data;

  modport master (
    output wr_valid, wr_tag, wr_tag_parity, wr_beat, wr_data, wr_parity, wr_cmd_kind,
    output rsp_valid, rsp_tag, rsp_ok, out_ready,
    input  out_valid, out_tag, out_kind, out_beat, out_last, out_data
  );

  modport slave (
    input  wr_valid, wr_tag, wr_tag_parity, wr_beat, wr_data, wr_parity, wr_cmd_kind,
    input  rsp_valid, rsp_tag, rsp_ok, out_ready,
    output out_valid, out_tag, out_kind, out_beat, out_last, out_data
  );

endinterface

// File: rtl/read_data_reassembly_rsp_tag_fifo.sv
// rtl/read_data_reassembly_rsp_tag_fifo.sv - synchronous FIFO of responding tags
module read_data_reassembly_rsp_tag_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  rd_ptr;
  logic [PW:0]  wr_ptr;
  logic         do_pop;
  logic         do_push;

  assign empty   = (rd_ptr == wr_ptr);
  assign full    = (rd_ptr[PW] != wr_ptr[PW]) && (rd_ptr[PW-1:0] == wr_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot, so a push into a full FIFO is legal in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/read_data_reassembly.sv
// rtl/read_data_reassembly.sv - stages PSL read beats per tag and streams each line on response
module read_data_reassembly
  import read_data_reassembly_pkg::*;
#(
  parameter int TAG_COUNT      = 256,
  parameter int BEATS          = 2,
  parameter int DATA_W         = 512,
  parameter int RSP_FIFO_DEPTH = 16
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    enabled_in,
  read_data_reassembly_if.slave   bus,
  output logic [3:0]              data_read_error
);
  localparam int TAG_W  = $clog2(TAG_COUNT);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW_N   = DATA_W / 64;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic enabled;

  logic                  wq_valid;
  logic [TAG_W-1:0]      wq_tag;
  logic                  wq_tag_par;
  logic [BEAT_W-1:0]     wq_beat;
  logic [DATA_W-1:0]     wq_data;
  logic [DW_N-1:0]       wq_par;
  logic [1:0]            wq_kind;
  logic                  wq_store;

  logic [DATA_W-1:0]     ram [TAG_COUNT * (2 ** BEAT_W)];
  logic [1:0]            kind_tab [TAG_COUNT];
  logic [BEATS-1:0]      bitmap [TAG_COUNT];
  logic [DATA_W-1:0]     rd_data;

  logic                  tag_err;
  logic [DW_N-1:0]       dw_err;

  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [TAG_W-1:0]      head_tag;
  logic                  head_hit;
  logic [BEATS-1:0]      snap;
  logic [1:0]            head_kind;

  fsm_state_e            state;
  fsm_state_e            state_next;
  logic [TAG_W-1:0]      cur_tag;
  logic [BEAT_W-1:0]     cur_beat;
  logic [1:0]            cur_kind;
  logic                  stream_valid;
  logic                  at_last;
  logic                  advance;
  reassembly_error_t     err_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      enabled  <= 1'b0;
      wq_valid <= 1'b0;
    end else begin
      enabled  <= enabled_in;
      wq_valid <= enabled && bus.wr_valid;
    end
  end

  always_ff @(posedge clock) begin
    wq_tag     <= bus.wr_tag;
    wq_tag_par <= bus.wr_tag_parity;
    wq_beat    <= bus.wr_beat;
    wq_data    <= bus.wr_data;
    wq_par     <= bus.wr_parity;
    wq_kind    <= bus.wr_cmd_kind;
  end

  assign wq_store = wq_valid && (wq_kind == KIND_READ || wq_kind == KIND_WED)
                    && (int'(wq_beat) < BEATS);

  always_ff @(posedge clock) begin
    if (wq_store) begin
      ram[{wq_tag, wq_beat}] <= wq_data;
      kind_tab[wq_tag]       <= wq_kind;
    end
    if (state == ST_FETCH) rd_data <= ram[{cur_tag, cur_beat}];
  end

  always_comb begin
    tag_err = wq_valid && !(^{wq_tag, wq_tag_par});
    dw_err  = '0;
    for (int i = 0; i < DW_N; i++) dw_err[i] = dw_parity_err(wq_data[64*i +: 64], wq_par[i]);
  end

  assign push = enabled && bus.rsp_valid && bus.rsp_ok;

  read_data_reassembly_rsp_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clock (clock),
    .rst   (rst),
    .flush (!enabled),
    .push  (push),
    .pop   (pop),
    .din   (bus.rsp_tag),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A beat still in the write latch belongs to the line being drained (write ordered first).
  assign head_hit  = wq_store && (wq_tag == head_tag);
  assign snap      = bitmap[head_tag] | (head_hit ? (BEATS'(1) << wq_beat) : '0);
  assign head_kind = head_hit ? wq_kind : kind_tab[head_tag];

  assign stream_valid = enabled && (state == ST_STREAM);
  assign at_last      = (cur_beat == LAST_BEAT);
  assign advance      = stream_valid && bus.out_ready;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH:  state_next = ST_STREAM;
      ST_STREAM: if (advance) state_next = at_last ? ST_IDLE : ST_FETCH;
      default:   state_next = ST_IDLE;
    endcase
    if (!enabled) begin
      pop        = 1'b0;
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cur_tag  <= '0;
      cur_beat <= '0;
      cur_kind <= '0;
      err_q    <= '0;
      for (int i = 0; i < TAG_COUNT; i++) bitmap[i] <= '0;
    end else begin
      err_q <= '0;
      if (!enabled) begin
        for (int i = 0; i < TAG_COUNT; i++) bitmap[i] <= '0;
      end else begin
        err_q.tag_par      <= tag_err;
        err_q.data_par     <= wq_valid && (|dw_err);
        err_q.rsp_overflow <= push && fifo_full && !pop;
        if (pop) begin
          cur_tag          <= head_tag;
          cur_beat         <= '0;
          cur_kind         <= head_kind;
          err_q.incomplete <= ~&snap;
          bitmap[head_tag] <= '0;
        end
        // Placed after the clear so a same-cycle write to the draining tag keeps its bit.
        if (wq_store) bitmap[wq_tag][wq_beat] <= 1'b1;
        if (advance && !at_last) cur_beat <= cur_beat + 1'b1;
      end
    end
  end

  assign data_read_error = err_q;
  assign bus.out_valid   = stream_valid;
  assign bus.out_last    = stream_valid && at_last;
  assign bus.out_tag     = stream_valid ? cur_tag  : '0;
  assign bus.out_kind    = stream_valid ? cur_kind : '0;
  assign bus.out_beat    = stream_valid ? cur_beat : '0;
  assign bus.out_data    = stream_valid ? rd_data  : '0;

endmodule

// File: tb/tb_read_data_reassembly.sv
// tb/tb_read_data_reassembly.sv - directed bench for read_data_reassembly
module tb_read_data_reassembly;
  localparam int DATA_W = 512;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       enabled_in = 1'b0;
  logic [3:0] data_read_error;
  int         n_total = 0;
  int         n_pass = 0;

  always #5 clock = ~clock;

  read_data_reassembly_if #(.TAG_COUNT(256), .BEATS(2), .DATA_W(DATA_W)) bus ();

  read_data_reassembly #(
    .TAG_COUNT(256), .BEATS(2), .DATA_W(DATA_W), .RSP_FIFO_DEPTH(16)
  ) dut (
    .clock           (clock),
    .rst             (rst),
    .enabled_in      (enabled_in),
    .bus             (bus.slave),
    .data_read_error (data_read_error)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic write_beat(input logic [7:0] tag, input logic beat, input logic [DATA_W-1:0] data,
                            input logic [1:0] kind, input logic bad_tag, input int bad_dw);
    logic [7:0] par;
    for (int i = 0; i < 8; i++) par[i] = ~^data[64*i +: 64];
    if (bad_dw >= 0) par[bad_dw] = ~par[bad_dw];
    bus.wr_valid      = 1'b1;
    bus.wr_tag        = tag;
    bus.wr_tag_parity = (~^tag) ^ bad_tag;
    bus.wr_beat       = beat;
    bus.wr_data       = data;
    bus.wr_parity     = par;
    bus.wr_cmd_kind   = kind;
    step();
    bus.wr_valid    = 1'b0;
    bus.wr_cmd_kind = 2'd0;
  endtask

  task automatic send_rsp(input logic [7:0] tag);
    bus.rsp_valid = 1'b1;
    bus.rsp_ok    = 1'b1;
    bus.rsp_tag   = tag;
    step();
    bus.rsp_valid = 1'b0;
  endtask

  task automatic get_beat(output logic [DATA_W-1:0] d, output logic [7:0] t, output logic [1:0] k,
                          output logic b, output logic l);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("beat_wait", bus.out_valid, 1'b1);
    d = bus.out_data;
    t = bus.out_tag;
    k = bus.out_kind;
    b = bus.out_beat;
    l = bus.out_last;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic get_line(input string name, input logic [7:0] tag, input logic [1:0] kind,
                          input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    logic [DATA_W-1:0] d;
    logic [7:0] t;
    logic [1:0] k;
    logic b, l;
    for (int i = 0; i < 2; i++) begin
      get_beat(d, t, k, b, l);
      check({name, "_tag"}, t, tag);
      check({name, "_kind"}, k, kind);
      check({name, "_beat"}, b, i[0]);
      check({name, "_last"}, l, i[0]);
      check({name, "_data"}, d, (i == 0) ? d0 : d1);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] da, db, dc, dd, de, df, dg, dh, di, dj, dk, dl, dm, dn, d;
    logic [7:0] t;
    logic [1:0] k;
    logic b, l;
    int ov_count;
    logic ov_last;
    logic seen;

    da = {8{64'h0123_4567_89ab_cdef}};
    db = {8{64'hfedc_ba98_7654_3210}};
    dc = {8{64'h1111_2222_3333_4444}};
    dd = {8{64'h5555_6666_7777_8888}};
    de = {8{64'h9999_aaaa_bbbb_cccc}};
    df = {8{64'hdead_beef_0000_0001}};
    dg = {8{64'hcafe_f00d_0000_0003}};
    dh = {8{64'h0000_0000_0000_00a1}};
    di = {8{64'h0000_0000_0000_00a2}};
    dj = {8{64'h1234_0000_0000_00b1}};
    dk = {8{64'h1234_0000_0000_00b2}};
    dl = {8{64'h7777_0000_0000_00c1}};
    dm = {8{64'h7777_0000_0000_00c2}};
    dn = {8{64'h4242_4242_4242_4242}};

    bus.wr_valid = 0; bus.wr_tag = 0; bus.wr_tag_parity = 0; bus.wr_beat = 0;
    bus.wr_data = '0; bus.wr_parity = 0; bus.wr_cmd_kind = 0;
    bus.rsp_valid = 0; bus.rsp_tag = 0; bus.rsp_ok = 0; bus.out_ready = 0;

    step(); step();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_error", data_read_error, 4'b0000);
    rst = 1'b0;
    enabled_in = 1'b1;
    step(); step();

    // Complete READ line, 3-cycle response latency.
    write_beat(8'h05, 1'b0, da, 2'd1, 1'b0, -1);
    write_beat(8'h05, 1'b1, db, 2'd1, 1'b0, -1);
    send_rsp(8'h05);
    check("lat_c1_valid", bus.out_valid, 1'b0);
    step();
    check("lat_c2_valid", bus.out_valid, 1'b0);
    check("t05_no_err", data_read_error, 4'b0000);
    step();
    check("lat_c3_valid", bus.out_valid, 1'b1);
    get_line("t05", 8'h05, 2'd1, da, db);
    check("t05_err_after", data_read_error, 4'b0000);

    // WED line held under back-pressure.
    write_beat(8'h07, 1'b0, dc, 2'd2, 1'b0, -1);
    write_beat(8'h07, 1'b1, dd, 2'd2, 1'b0, -1);
    send_rsp(8'h07);
    step(); step();
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_data", bus.out_data, dc);
      check("hold_beat", bus.out_beat, 1'b0);
      step();
    end
    get_line("t07", 8'h07, 2'd2, dc, dd);

    // Beat 0 only -> incomplete, still two beats.
    write_beat(8'h09, 1'b0, de, 2'd1, 1'b0, -1);
    send_rsp(8'h09);
    step();
    check("t09_incomplete", data_read_error, 4'b0010);
    step();
    check("t09_pulse_end", data_read_error, 4'b0000);
    get_beat(d, t, k, b, l);
    check("t09_b0_data", d, de);
    check("t09_b0_last", l, 1'b0);
    get_beat(d, t, k, b, l);
    check("t09_b1_beat", b, 1'b1);
    check("t09_b1_last", l, 1'b1);

    // Tag and data parity errors; data still stored.
    write_beat(8'h0b, 1'b0, df, 2'd1, 1'b1, -1);
    step();
    check("tag_par_pulse", data_read_error, 4'b1000);
    write_beat(8'h0b, 1'b1, dg, 2'd1, 1'b0, 3);
    check("par_gap", data_read_error, 4'b0000);
    step();
    check("data_par_pulse", data_read_error, 4'b0100);
    send_rsp(8'h0b);
    step();
    check("t0b_complete", data_read_error, 4'b0000);
    get_line("t0b", 8'h0b, 2'd1, df, dg);

    // One line stalled in STREAM, then 17 responses into a 16-deep FIFO.
    send_rsp(8'h05);
    step(); step();
    check("ovf_stall_valid", bus.out_valid, 1'b1);
    ov_count = 0;
    ov_last = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.rsp_valid = 1'b1; bus.rsp_ok = 1'b1; bus.rsp_tag = 8'h10 + 8'(i);
      step();
      ov_count += int'(data_read_error[0]);
      if (i == 16) ov_last = data_read_error[0];
    end
    bus.rsp_valid = 1'b0;
    step();
    ov_count += int'(data_read_error[0]);
    check("ovf_count", ov_count, 1);
    check("ovf_on_17th", ov_last, 1'b1);
    for (int ln = 0; ln < 17; ln++) begin
      for (int bt = 0; bt < 2; bt++) begin
        get_beat(d, t, k, b, l);
        check("drain_tag", t, (ln == 0) ? 8'h05 : 8'h10 + 8'(ln - 1));
        check("drain_beat", b, bt[0]);
        check("drain_last", l, bt[0]);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= bus.out_valid;
      step();
    end
    check("drain_fifo_empty", seen, 1'b0);

    // Disable mid-stream with a second response queued.
    write_beat(8'h30, 1'b0, dh, 2'd1, 1'b0, -1);
    write_beat(8'h30, 1'b1, di, 2'd1, 1'b0, -1);
    send_rsp(8'h30);
    send_rsp(8'h31);
    step();
    check("dis_pre_valid", bus.out_valid, 1'b1);
    enabled_in = 1'b0;
    step();
    check("dis_valid", bus.out_valid, 1'b0);
    check("dis_last", bus.out_last, 1'b0);
    step(); step();
    enabled_in = 1'b1;
    step(); step();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= bus.out_valid;
      step();
    end
    check("dis_flushed", seen, 1'b0);
    write_beat(8'h32, 1'b0, dj, 2'd1, 1'b0, -1);
    write_beat(8'h32, 1'b1, dk, 2'd1, 1'b0, -1);
    send_rsp(8'h32);
    step();
    check("reen_no_err", data_read_error, 4'b0000);
    get_line("t32", 8'h32, 2'd1, dj, dk);

    // Asynchronous reset while FETCH is in progress.
    write_beat(8'h42, 1'b1, dn, 2'd1, 1'b0, -1);
    write_beat(8'h40, 1'b0, da, 2'd1, 1'b0, -1);
    write_beat(8'h40, 1'b1, db, 2'd1, 1'b0, -1);
    send_rsp(8'h40);
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_data", bus.out_data, '0);
    check("arst_tag", bus.out_tag, 8'h00);
    check("arst_error", data_read_error, 4'b0000);
    step(); step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      seen |= bus.out_valid;
    end
    check("arst_idle", seen, 1'b0);
    write_beat(8'h41, 1'b0, dl, 2'd2, 1'b0, -1);
    write_beat(8'h41, 1'b1, dm, 2'd2, 1'b0, -1);
    send_rsp(8'h41);
    step();
    check("t41_no_err", data_read_error, 4'b0000);
    get_line("t41", 8'h41, 2'd2, dl, dm);
    write_beat(8'h42, 1'b0, dn, 2'd1, 1'b0, -1);
    send_rsp(8'h42);
    step();
    check("t42_bitmap_reset", data_read_error, 4'b0010);
    get_beat(d, t, k, b, l);
    check("t42_b0_data", d, dn);
    get_beat(d, t, k, b, l);
    check("t42_b1_last", l, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
